// File: rtl/image_pkg.sv
// Shared image-pipeline types: RGB565 pixel, 8x8 block flags, luma coefficients.
package image_pkg;

    localparam int unsigned PIX_W    = 16;
    localparam int unsigned BLK_SIZE = 8;

    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic sob;
        logic eob;
        logic eof;
    } blk_flags_t;

    // RGB565 -> 8-bit luma; channels widened to 8 bits by replicating their MSBs.
    // The weighted sum peaks at 255*256, so 16 bits hold it without overflow.
    function automatic logic [7:0] rgb565_to_y(input pixel_t p);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] acc;
        r8  = {p[15:11], p[15:13]};
        g8  = {p[10:5], p[10:9]};
        b8  = {p[4:0], p[4:2]};
        acc = 16'(LUMA_R) * 16'(r8) + 16'(LUMA_G) * 16'(g8) + 16'(LUMA_B) * 16'(b8);
        return 8'(acc >> 8);
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank simple dual-port pixel RAM with a registered read port.
// Ports: write (wr_en, wr_bank, wr_addr, wr_data); read (rd_en, rd_bank,
// rd_addr) with rd_data valid the cycle after rd_en and held otherwise.
module pingpong_ram
    import image_pkg::*;
#(
    parameter int unsigned DEPTH  = 192,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data
);

    pixel_t mem [0:1][0:DEPTH-1];

    // Storage array: no reset, write-only port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Read register: cleared on reset, holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-8x8-block reorder buffer: collects 8-line strips of RGB565 pixels
// into a ping-pong RAM and replays each strip block by block (blocks left to
// right, rows top to bottom inside a block).
// Ports: clk, rst (sync, active high); input stream in_valid/in_ready/in_data/
// in_sof; output stream out_valid/out_ready/out_data with out_sob/out_eob/out_eof.
// Build option: define RGB2Y_EN to emit 8-bit luma in out_data[7:0] through
// one extra output register stage.
module raster_to_block
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned HEIGHT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sob,
    output logic        out_eob,
    output logic        out_eof
);

    localparam int unsigned DEPTH  = BLK_SIZE * WIDTH;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned COL_W  = $clog2(WIDTH);
    localparam int unsigned ROW_W  = $clog2(BLK_SIZE);
    localparam int unsigned NBX    = WIDTH / BLK_SIZE;
    localparam int unsigned NS     = HEIGHT / BLK_SIZE;
    localparam int unsigned BX_W   = (NBX > 1) ? $clog2(NBX) : 1;
    localparam int unsigned RS_W   = (NS > 1) ? $clog2(NS) : 1;

    // Write side
    logic [COL_W-1:0]  wcol;
    logic [ROW_W-1:0]  wrow;
    logic              wbank;
    logic              wbank_nxt;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              accept;
    logic              wr_last;
    logic              fill;
    logic [ADDR_W-1:0] wr_addr;

    // Read side
    logic [ROW_W-1:0]  rc;
    logic [ROW_W-1:0]  rr;
    logic [BX_W-1:0]   bx;
    logic [RS_W-1:0]   rs;
    logic              rd_bank;
    logic              rel_bank;
    logic              advance;
    logic              issue;
    logic              px_last;
    logic              blk_last;
    logic [ADDR_W-1:0] rd_addr;
    logic              rel_strip;
    logic              v1;
    logic              se1;
    logic              se_out;
    blk_flags_t        f1;
    pixel_t            ram_rdata;

    // Write addressing; in_sof restarts the strip at address 0.
    always_comb begin
        accept  = in_valid && in_ready;
        wr_last = (wrow == ROW_W'(BLK_SIZE - 1)) && (wcol == COL_W'(WIDTH - 1));
        fill    = accept && !in_sof && wr_last;
        wr_addr = in_sof ? '0 : ADDR_W'(ADDR_W'(wrow) * ADDR_W'(WIDTH) + ADDR_W'(wcol));
    end

    // Write position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcol <= '0;
            wrow <= '0;
        end else if (accept) begin
            if (in_sof) begin
                wcol <= COL_W'(1);
                wrow <= '0;
            end else if (wcol == COL_W'(WIDTH - 1)) begin
                wcol <= '0;
                wrow <= wr_last ? '0 : wrow + ROW_W'(1);
            end else begin
                wcol <= wcol + COL_W'(1);
            end
        end
    end

    // Bank ownership: fill and release always hit different banks.
    always_comb begin
        full_nxt = full;
        if (rel_strip) begin
            full_nxt[rel_bank] = 1'b0;
        end
        if (fill) begin
            full_nxt[wbank] = 1'b1;
        end
        wbank_nxt = wbank ^ fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wbank    <= 1'b0;
            rel_bank <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            full     <= full_nxt;
            wbank    <= wbank_nxt;
            rel_bank <= rel_bank ^ rel_strip;
            in_ready <= !full_nxt[wbank_nxt];
        end
    end

    // Read issue: the whole output pipe advances together, so a stall freezes it.
    always_comb begin
        advance   = !out_valid || out_ready;
        issue     = full[rd_bank] && advance;
        px_last   = (rc == ROW_W'(BLK_SIZE - 1)) && (rr == ROW_W'(BLK_SIZE - 1));
        blk_last  = (bx == BX_W'(NBX - 1));
        rd_addr   = ADDR_W'(rr) * ADDR_W'(WIDTH) + ADDR_W'(bx) * ADDR_W'(BLK_SIZE) + ADDR_W'(rc);
        rel_strip = out_valid && out_ready && se_out;
    end

    // Block-order read counters. rd_bank runs ahead of rel_bank so the next strip
    // can start while the last pixel of the previous one is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc      <= '0;
            rr      <= '0;
            bx      <= '0;
            rs      <= '0;
            rd_bank <= 1'b0;
        end else if (issue) begin
            if (rc == ROW_W'(BLK_SIZE - 1)) begin
                rc <= '0;
                if (rr == ROW_W'(BLK_SIZE - 1)) begin
                    rr <= '0;
                    if (blk_last) begin
                        bx      <= '0;
                        rd_bank <= ~rd_bank;
                        rs      <= (rs == RS_W'(NS - 1)) ? '0 : rs + RS_W'(1);
                    end else begin
                        bx <= bx + BX_W'(1);
                    end
                end else begin
                    rr <= rr + ROW_W'(1);
                end
            end else begin
                rc <= rc + ROW_W'(1);
            end
        end
    end

    // Flags travel alongside the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            f1  <= '0;
            se1 <= 1'b0;
        end else if (advance) begin
            v1     <= issue;
            f1.sob <= issue && (rc == '0) && (rr == '0);
            f1.eob <= issue && px_last;
            f1.eof <= issue && px_last && blk_last && (rs == RS_W'(NS - 1));
            se1    <= issue && px_last && blk_last;
        end
    end

    pingpong_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_bank (wbank),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_en   (issue),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

`ifdef RGB2Y_EN
    logic se2;

    // Luma conversion register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_eof   <= 1'b0;
            se2       <= 1'b0;
        end else if (advance) begin
            out_valid <= v1;
            out_data  <= {8'h00, rgb565_to_y(ram_rdata)};
            out_sob   <= f1.sob;
            out_eob   <= f1.eob;
            out_eof   <= f1.eof;
            se2       <= se1;
        end
    end

    assign se_out = se2;
`else
    assign out_valid = v1;
    assign out_data  = ram_rdata;
    assign out_sob   = f1.sob;
    assign out_eob   = f1.eob;
    assign out_eof   = f1.eof;
    assign se_out    = se1;
`endif

endmodule
